// File: rtl/echo_indication_pkg.sv
// Shared message layout and helpers for the echo indication arbiter.
// Used by the round-robin picker and the arbiter top.
package echo_indication_pkg;

  localparam int MSG_W = 96;

  localparam int TAG_LSB  = 0;
  localparam int TAG_W    = 32;
  localparam int METH_LSB = 32;
  localparam int METH_W   = 32;
  localparam int V_LSB    = 64;
  localparam int V_W      = 32;

  localparam int TAG_HEARD = 1;

  function automatic logic tag_legal(
    input logic [MSG_W-1:0] m,
    input int               num_tags
  );
    return m[TAG_LSB +: TAG_W] < 32'(num_tags);
  endfunction

endpackage

// File: rtl/echo_indication_arbiter_rr_pick.sv
// Circular priority encoder: first pending index at or after ptr.
// Purely combinational; sel is 0 when nothing is pending.
module rr_pick
  import echo_indication_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any
);

  always_comb begin
    sel = '0;
    any = |pending;
    // Walk offsets from far to near so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (pending[(int'(ptr) + k) % N]) begin
        sel = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/echo_indication_arbiter.sv
// Round-robin scheduler sharing the demux enq method among NREQ sources,
// with bounded bursts, tag filtering and a one-entry output register.
module echo_indication_arbiter
  import echo_indication_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NUM_TAGS  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_pending,
  input  logic [NREQ-1:0]       req__ENA,
  input  logic [NREQ*MSG_W-1:0] req_v,
  output logic [NREQ-1:0]       req__RDY,
  output logic                  enq__ENA,
  output logic [MSG_W-1:0]      enq_v,
  input  logic                  enq__RDY,
  output logic [15:0]           drop_count
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic             out_valid;
  logic [MSG_W-1:0] out_data;
  logic [PW-1:0]    ptr;
  logic [3:0]       burst;

  logic [PW-1:0]    sel;
  logic [PW-1:0]    ptr_rot;
  logic             any;
  logic             can_accept;
  logic             grant_ok;
  logic             xfer;
  logic             legal;
  logic             others;
  logic             burst_more;
  logic [NREQ-1:0]  sel_oh;
  logic [MSG_W-1:0] msg;

  rr_pick #(
    .N(NREQ)
  ) u_pick (
    .pending(req_pending),
    .ptr    (ptr),
    .sel    (sel),
    .any    (any)
  );

  assign can_accept = !out_valid || enq__RDY;
  assign grant_ok   = !RST && can_accept && any;
  assign sel_oh     = NREQ'(1) << sel;
  assign req__RDY   = grant_ok ? sel_oh : '0;

  assign enq__ENA = !RST && out_valid && enq__RDY;
  assign enq_v    = out_data;

  assign xfer   = grant_ok && req__ENA[sel];
  assign msg    = req_v[int'(sel)*MSG_W +: MSG_W];
  assign legal  = tag_legal(msg, NUM_TAGS);
  assign others = |(req_pending & ~sel_oh);

  assign burst_more = ({1'b0, burst} + 5'd1) < 5'(MAX_BURST);
  assign ptr_rot    = (sel == LAST) ? '0 : sel + PW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      ptr        <= '0;
      burst      <= '0;
      drop_count <= '0;
    end else begin
      // A load overwrites a draining entry, so valid stays up.
      if (xfer && legal) begin
        out_valid <= 1'b1;
        out_data  <= msg;
      end else if (enq__ENA) begin
        out_valid <= 1'b0;
      end

      if (xfer && !legal && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end

      if (xfer) begin
        if (!others) begin
          burst <= '0;
        end else if (burst_more) begin
          ptr   <= sel;
          burst <= burst + 4'd1;
        end else begin
          ptr   <= ptr_rot;
          burst <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_indication_arbiter.sv
// Directed bench for echo_indication_arbiter: table-driven vectors
// plus hand sequences for backpressure, drops and mid-run reset.
module tb_echo_indication_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   pend;
  logic [3:0]   ena;
  logic [383:0] rv;
  logic [3:0]   rdy;
  logic         enq_ena;
  logic [95:0]  enq_v;
  logic         rdy_in;
  logic [15:0]  drops;

  int checks = 0;
  int errors = 0;

  echo_indication_arbiter #(
    .NREQ(4),
    .NUM_TAGS(2),
    .MAX_BURST(4)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .req_pending(pend),
    .req__ENA   (ena),
    .req_v      (rv),
    .req__RDY   (rdy),
    .enq__ENA   (enq_ena),
    .enq_v      (enq_v),
    .enq__RDY   (rdy_in),
    .drop_count (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pend;
    logic [3:0] ena;
    logic       rdy_in;
    logic [3:0] exp_rdy;
    logic       exp_ena;
    int         exp_src;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [95:0] msg(input int src, input logic [31:0] tag);
    return {32'hC0DE0000 | 32'(src), 32'(src), tag};
  endfunction

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] p, input logic [3:0] e,
                     input logic r);
    @(posedge clk);
    #1;
    pend   = p;
    ena    = e;
    rdy_in = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    pend = '0;
    ena = '0;
    rdy_in = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 96'(rdy), 96'(0));
    chk("rst_enq_ena", 96'(enq_ena), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drops", 96'(drops), 96'(0));
    chk("rst_enq_v", enq_v, 96'(0));
  endtask

  initial begin
    rst = 1'b1;
    pend = '0;
    ena = '0;
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) rv[i*96 +: 96] = msg(i, 32'd1);

    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{4'b0100, 4'b0100, 1'b1, 4'b0100, i > 0, 2});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0});
    for (int i = 0; i < 17; i++) begin
      int g;
      int pg;
      g  = (i / 4) % 4;
      pg = (i > 0) ? ((i - 1) / 4) % 4 : 0;
      tbl.push_back('{4'hF, 4'(1) << g, 1'b1, 4'(1) << g, i > 0, pg});
    end
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 0});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0});

    do_reset();

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].pend, tbl[k].ena, tbl[k].rdy_in);
      chk($sformatf("tbl%0d_rdy", k), 96'(rdy), 96'(tbl[k].exp_rdy));
      chk($sformatf("tbl%0d_enq_ena", k), 96'(enq_ena), 96'(tbl[k].exp_ena));
      if (tbl[k].exp_ena)
        chk($sformatf("tbl%0d_enq_v", k), enq_v, msg(tbl[k].exp_src, 32'd1));
    end

    // Backpressure: held entry stays put, release drains and reloads.
    do_reset();
    cyc(4'b1000, 4'b1000, 1'b0);
    chk("bp_load_rdy", 96'(rdy), 96'(4'b1000));
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1000, 4'b0000, 1'b0);
      rv[3*96 +: 96] = {32'h5555AAAA, 32'd3, 32'd1};
      chk($sformatf("bp%0d_rdy", i), 96'(rdy), 96'(0));
      chk($sformatf("bp%0d_enq_ena", i), 96'(enq_ena), 96'(0));
      chk($sformatf("bp%0d_enq_v", i), enq_v, msg(3, 32'd1));
    end
    cyc(4'b1000, 4'b1000, 1'b1);
    chk("bp_rel_rdy", 96'(rdy), 96'(4'b1000));
    chk("bp_rel_enq_ena", 96'(enq_ena), 96'(1));
    chk("bp_rel_enq_v", enq_v, msg(3, 32'd1));
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("bp_next_enq_ena", 96'(enq_ena), 96'(1));
    chk("bp_next_enq_v", enq_v, {32'h5555AAAA, 32'd3, 32'd1});
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("bp_empty_enq_ena", 96'(enq_ena), 96'(0));
    rv[3*96 +: 96] = msg(3, 32'd1);

    // Illegal tags: handshake completes, nothing is enqueued.
    do_reset();
    rv[1*96 +: 96] = msg(1, 32'd7);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0010, 4'b0010, 1'b1);
      chk($sformatf("drop%0d_rdy", i), 96'(rdy), 96'(4'b0010));
      chk($sformatf("drop%0d_enq_ena", i), 96'(enq_ena), 96'(0));
    end
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("drop_enq_ena", 96'(enq_ena), 96'(0));
    chk("drop_count3", 96'(drops), 96'(3));
    force dut.drop_count = 16'hFFFF;
    #1;
    release dut.drop_count;
    cyc(4'b0010, 4'b0010, 1'b1);
    chk("sat_rdy", 96'(rdy), 96'(4'b0010));
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("sat_count", 96'(drops), 96'(16'hFFFF));
    chk("sat_enq_ena", 96'(enq_ena), 96'(0));
    rv[1*96 +: 96] = msg(1, 32'd1);

    // Reset while holding a message after the pointer has moved.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0011, 4'b0001, 1'b1);
      chk($sformatf("mr%0d_rdy", i), 96'(rdy), 96'(4'b0001));
    end
    cyc(4'b0011, 4'b0010, 1'b1);
    chk("mr_rot_rdy", 96'(rdy), 96'(4'b0010));
    cyc(4'b0011, 4'b0000, 1'b0);
    chk("mr_hold_rdy", 96'(rdy), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    pend = 4'b1001;
    ena = '0;
    rdy_in = 1'b1;
    @(negedge clk);
    chk("mr_in_rst_rdy", 96'(rdy), 96'(0));
    chk("mr_in_rst_enq_ena", 96'(enq_ena), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_post_enq_ena", 96'(enq_ena), 96'(0));
    chk("mr_post_drops", 96'(drops), 96'(0));
    chk("mr_post_rdy", 96'(rdy), 96'(4'b0001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
